// File: rtl/remote_cmd_sequencer.sv
// remote_cmd_sequencer: queues 16-bit Knight commands and issues them one at a
// time to RemoteComm. Each command waits for cmd_sent and then for a one-byte
// response, with a timeout per wait phase. A NAK or a timeout halts the block
// until clr_err.
module remote_cmd_sequencer #(
    parameter int unsigned DEPTH          = 8,
    parameter int unsigned TIMEOUT_CYCLES = 4000000,
    parameter logic [7:0]  ACK_VAL        = 8'hA5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push,
    input  logic [15:0] push_cmd,
    input  logic        flush,
    input  logic        clr_err,
    output logic        full,
    output logic        empty,
    output logic [15:0] cmd,
    output logic        send_cmd,
    input  logic        cmd_sent,
    input  logic        resp_rdy,
    input  logic [7:0]  resp,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [1:0]  err_code,
    output logic        ovf,
    output logic [7:0]  ack_cnt
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        IDLE,
        SEND,
        WAIT_SENT,
        WAIT_RESP,
        HALT
    } state_t;

    state_t        state;
    logic [TW-1:0] timer;
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic [15:0]   mem [DEPTH];
    logic          pop;
    logic          push_ok;
    logic          push_drop;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // The head is fetched and popped on the IDLE->SEND edge so that cmd and
    // the registered send_cmd pulse appear together during SEND.
    assign pop       = (state == IDLE) && !empty;
    assign push_ok   = push && !flush && (!full || pop);
    assign push_drop = push && !flush && full && !pop;

    // FIFO storage write; contents need no reset since the pointers gate them
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr[AW-1:0]] <= push_cmd;
        end
    end

    // FIFO pointers; flush discards everything queued and overrides a pop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (flush) begin
                rd_ptr <= wr_ptr;
            end else if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Sticky overflow flag: cleared by clr_err in any state, set by a dropped push
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else begin
            if (clr_err) begin
                ovf <= 1'b0;
            end
            if (push_drop) begin
                ovf <= 1'b1;
            end
        end
    end

    // Command sequencing FSM with registered outputs and a saturating phase timer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            timer    <= '0;
            cmd      <= '0;
            send_cmd <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            err_code <= 2'b00;
            ack_cnt  <= '0;
        end else begin
            send_cmd <= 1'b0;
            done     <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (!empty) begin
                        cmd      <= mem[rd_ptr[AW-1:0]];
                        send_cmd <= 1'b1;
                        busy     <= 1'b1;
                        state    <= SEND;
                    end
                end
                SEND: begin
                    timer <= '0;
                    state <= WAIT_SENT;
                end
                WAIT_SENT: begin
                    if (cmd_sent) begin
                        timer <= '0;
                        state <= WAIT_RESP;
                    end else if (timer == TMAX) begin
                        err      <= 1'b1;
                        err_code <= 2'b10;
                        state    <= HALT;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                WAIT_RESP: begin
                    if (resp_rdy) begin
                        if (resp == ACK_VAL) begin
                            done    <= 1'b1;
                            ack_cnt <= ack_cnt + 8'd1;
                            busy    <= 1'b0;
                            state   <= IDLE;
                        end else begin
                            err      <= 1'b1;
                            err_code <= 2'b01;
                            state    <= HALT;
                        end
                    end else if (timer == TMAX) begin
                        err      <= 1'b1;
                        err_code <= 2'b11;
                        state    <= HALT;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                HALT: begin
                    if (clr_err) begin
                        err      <= 1'b0;
                        err_code <= 2'b00;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_remote_cmd_sequencer.sv
// Scoreboard bench for remote_cmd_sequencer: a RemoteComm responder model acts
// on each send_cmd, and a monitor compares every send_cmd/done/err event against
// the queues filled when the stimulus was issued.
module tb_remote_cmd_sequencer;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned TMO   = 100;
    localparam logic [7:0]  ACK   = 8'hA5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        push = 1'b0;
    logic [15:0] push_cmd = '0;
    logic        flush = 1'b0;
    logic        clr_err = 1'b0;
    logic        cmd_sent = 1'b0;
    logic        resp_rdy = 1'b0;
    logic [7:0]  resp = '0;
    logic        full, empty, send_cmd, busy, done, err, ovf;
    logic [15:0] cmd;
    logic [1:0]  err_code;
    logic [7:0]  ack_cnt;

    always #5 clk = ~clk;

    remote_cmd_sequencer #(
        .DEPTH(DEPTH),
        .TIMEOUT_CYCLES(TMO),
        .ACK_VAL(ACK)
    ) dut (
        .clk(clk), .rst_n(rst_n), .push(push), .push_cmd(push_cmd),
        .flush(flush), .clr_err(clr_err), .full(full), .empty(empty),
        .cmd(cmd), .send_cmd(send_cmd), .cmd_sent(cmd_sent),
        .resp_rdy(resp_rdy), .resp(resp), .busy(busy), .done(done),
        .err(err), .err_code(err_code), .ovf(ovf), .ack_cnt(ack_cnt)
    );

    // sd/rd: cycles into WAIT_SENT / WAIT_RESP before the responder answers;
    // a value above TMO means the responder stays silent in that phase.
    typedef struct {
        int unsigned sd;
        int unsigned rd;
        logic [7:0]  rv;
    } plan_t;

    plan_t       plans[$];
    logic [15:0] exp_cmd[$];
    logic [1:0]  exp_out[$];
    int unsigned model_acks = 0;
    int          errors = 0;
    int          checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Outcome of a command from the responder's behaviour alone
    function automatic logic [1:0] outcome(input plan_t p);
        if (p.sd > TMO) return 2'b10;
        if (p.rd > TMO) return 2'b11;
        if (p.rv != ACK) return 2'b01;
        return 2'b00;
    endfunction

    function automatic plan_t mk(input int unsigned sd, input int unsigned rd, input logic [7:0] rv);
        plan_t p;
        p.sd = sd;
        p.rd = rd;
        p.rv = rv;
        return p;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_cmd(input logic [15:0] c, input plan_t p);
        exp_cmd.push_back(c);
        plans.push_back(p);
        exp_out.push_back(outcome(p));
    endtask

    task automatic push_one(input logic [15:0] c);
        push = 1'b1;
        push_cmd = c;
        step();
        push = 1'b0;
    endtask

    task automatic pulse_clr();
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
    endtask

    task automatic wait_quiet(input string name, input int unsigned max);
        int unsigned n = 0;
        while (!(exp_out.size() == 0 && exp_cmd.size() == 0 && !busy) && n < max) begin
            step();
            n++;
        end
        chk(name, n < max, 1'b1);
    endtask

    task automatic wait_err(input string name, input int unsigned max, output int unsigned n);
        n = 0;
        while (!err && n < max) begin
            step();
            n++;
        end
        chk(name, err, 1'b1);
    endtask

    task automatic wait_send(input string name);
        int unsigned n = 0;
        while (!send_cmd && n < 50) begin
            step();
            n++;
        end
        chk(name, send_cmd, 1'b1);
    endtask

    // RemoteComm responder: answers each issued command according to its plan
    initial begin : responder
        plan_t p;
        forever begin
            @(negedge clk);
            if (rst_n && send_cmd && plans.size() != 0) begin
                p = plans.pop_front();
                if (p.sd <= TMO) begin
                    @(posedge clk);
                    #1;
                    repeat (p.sd) begin @(posedge clk); #1; end
                    cmd_sent = 1'b1;
                    @(posedge clk);
                    #1;
                    cmd_sent = 1'b0;
                    if (p.rd <= TMO) begin
                        repeat (p.rd) begin @(posedge clk); #1; end
                        resp = p.rv;
                        resp_rdy = 1'b1;
                        @(posedge clk);
                        #1;
                        resp_rdy = 1'b0;
                    end
                end
            end
        end
    end

    // Monitor: pops the scoreboard on every send_cmd, done and err rising edge
    initial begin : monitor
        logic send_q, done_q, err_q;
        logic [1:0] o;
        send_q = 1'b0;
        done_q = 1'b0;
        err_q  = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                send_q = 1'b0;
                done_q = 1'b0;
                err_q  = 1'b0;
            end else begin
                if (send_cmd) begin
                    chk("send_cmd single cycle", send_q, 1'b0);
                    chk("send_cmd while halted", err, 1'b0);
                    chk("send_cmd expected", exp_cmd.size() != 0, 1'b1);
                    if (exp_cmd.size() != 0) chk("cmd order", cmd, exp_cmd.pop_front());
                end
                if (done) begin
                    chk("done single cycle", done_q, 1'b0);
                    chk("done expected", exp_out.size() != 0, 1'b1);
                    if (exp_out.size() != 0) begin
                        o = exp_out.pop_front();
                        chk("done outcome", 2'b00, o);
                        if (o == 2'b00) model_acks++;
                        chk("ack_cnt at done", ack_cnt, 32'(model_acks[7:0]));
                    end
                end
                if (err && !err_q) begin
                    chk("err expected", exp_out.size() != 0, 1'b1);
                    if (exp_out.size() != 0) chk("err_code", err_code, exp_out.pop_front());
                end
                send_q = send_cmd;
                done_q = done;
                err_q  = err;
            end
        end
    end

    initial begin : watchdog
        #400000;
        errors++;
        $display("FAIL watchdog: bench did not complete in time");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : main
        int unsigned n;
        plan_t p;
        logic [15:0] c;

        // Reset
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset cmd", cmd, 16'h0);
        chk("reset send_cmd", send_cmd, 1'b0);
        chk("reset busy", busy, 1'b0);
        chk("reset done", done, 1'b0);
        chk("reset err", err, 1'b0);
        chk("reset err_code", err_code, 2'b00);
        chk("reset ovf", ovf, 1'b0);
        chk("reset ack_cnt", ack_cnt, 8'd0);
        chk("reset empty", empty, 1'b1);
        chk("reset full", full, 1'b0);
        rst_n = 1'b1;
        step();

        // Single command with push->send latency
        expect_cmd(16'h2000, mk(9, 40, ACK));
        push_one(16'h2000);
        chk("latency idle cycle send_cmd", send_cmd, 1'b0);
        step();
        chk("latency send_cmd", send_cmd, 1'b1);
        chk("latency cmd", cmd, 16'h2000);
        wait_quiet("single quiet", 200);
        chk("single ack_cnt", ack_cnt, 8'd1);
        chk("single err", err, 1'b0);
        chk("single busy", busy, 1'b0);

        // Back-to-back pushes
        expect_cmd(16'h2000, mk(2, 3, ACK));
        expect_cmd(16'h4001, mk(0, 0, ACK));
        expect_cmd(16'h5002, mk(4, 1, ACK));
        push_one(16'h2000);
        push_one(16'h4001);
        push_one(16'h5002);
        wait_quiet("b2b quiet", 300);
        chk("b2b ack_cnt", ack_cnt, 8'd4);
        chk("b2b empty", empty, 1'b1);

        // NAK halts issue until clr_err
        expect_cmd(16'h6003, mk(3, 5, 8'h5A));
        expect_cmd(16'h7004, mk(1, 2, ACK));
        push_one(16'h6003);
        push_one(16'h7004);
        wait_err("nak err", 200, n);
        repeat (20) step();
        chk("nak holds queue", empty, 1'b0);
        chk("nak err sticky", err, 1'b1);
        chk("nak err_code", err_code, 2'b01);
        chk("nak busy", busy, 1'b1);
        pulse_clr();
        chk("nak cleared err", err, 1'b0);
        wait_quiet("nak quiet", 200);
        chk("nak ack_cnt", ack_cnt, 8'd5);
        chk("nak err_code cleared", err_code, 2'b00);

        // cmd_sent timeout
        expect_cmd(16'h1111, mk(TMO + 1, 0, ACK));
        push_one(16'h1111);
        wait_send("to10 send");
        wait_err("to10 err", 300, n);
        chk("to10 latency", n, TMO + 2);
        chk("to10 cmd held", cmd, 16'h1111);
        pulse_clr();

        // response timeout
        expect_cmd(16'h2222, mk(5, TMO + 1, ACK));
        push_one(16'h2222);
        wait_send("to11 send");
        wait_err("to11 err", 300, n);
        chk("to11 latency", n, 5 + TMO + 3);
        pulse_clr();

        // Answers arriving exactly at timer==TIMEOUT win
        expect_cmd(16'h3333, mk(TMO, TMO, ACK));
        push_one(16'h3333);
        wait_quiet("edge quiet", 400);
        chk("edge no err", err, 1'b0);
        chk("edge ack_cnt", ack_cnt, 8'd6);

        // Overflow and flush while halted, then push-at-full with pop
        expect_cmd(16'h4444, mk(1, 1, 8'h00));
        push_one(16'h4444);
        wait_err("halt err", 100, n);
        for (int i = 0; i < int'(DEPTH); i++) push_one(16'hE000 + 16'(i));
        chk("fill full", full, 1'b1);
        chk("fill ovf", ovf, 1'b0);
        push_one(16'hEEEE);
        chk("extra full", full, 1'b1);
        chk("extra ovf", ovf, 1'b1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush empty", empty, 1'b1);
        chk("flush full", full, 1'b0);
        chk("flush ovf kept", ovf, 1'b1);
        for (int i = 0; i < int'(DEPTH); i++) begin
            c = 16'hA000 + 16'(i);
            expect_cmd(c, mk($urandom_range(0, 4), $urandom_range(0, 4), ACK));
            push_one(c);
        end
        chk("refill full", full, 1'b1);
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        chk("clr ovf", ovf, 1'b0);
        chk("clr err", err, 1'b0);
        expect_cmd(16'hABCD, mk(2, 2, ACK));
        push_one(16'hABCD);
        chk("pop+push at full ovf", ovf, 1'b0);
        chk("pop+push at full full", full, 1'b1);
        wait_quiet("refill quiet", 600);
        chk("refill ack_cnt", ack_cnt, 8'd11);
        chk("refill empty", empty, 1'b1);

        // Randomized traffic
        for (int k = 0; k < 24; k++) begin
            n = 0;
            while (exp_cmd.size() >= DEPTH - 1 && n < 400) begin
                if (err) pulse_clr(); else step();
                n++;
            end
            chk("rand space", n < 400, 1'b1);
            p.sd = ($urandom_range(0, 9) == 0) ? TMO : $urandom_range(0, 12);
            p.rd = ($urandom_range(0, 9) == 0) ? TMO : $urandom_range(0, 12);
            p.rv = ACK;
            if ($urandom_range(0, 5) == 0) begin
                p.rv = 8'($urandom_range(0, 255));
                if (p.rv == ACK) p.rv = 8'h00;
            end
            c = 16'($urandom);
            expect_cmd(c, p);
            push_one(c);
            repeat ($urandom_range(0, 3)) step();
        end
        n = 0;
        while (!(exp_out.size() == 0 && exp_cmd.size() == 0 && !busy) && n < 3000) begin
            if (err) pulse_clr(); else step();
            n++;
        end
        chk("rand drain", n < 3000, 1'b1);
        chk("rand ack_cnt", ack_cnt, 32'(model_acks[7:0]));
        chk("rand empty", empty, 1'b1);

        // Reset during WAIT_RESP with two commands queued
        expect_cmd(16'h0A0A, mk(2, TMO + 1, ACK));
        expect_cmd(16'h0B0B, mk(1, 1, ACK));
        expect_cmd(16'h0C0C, mk(1, 1, ACK));
        push_one(16'h0A0A);
        push_one(16'h0B0B);
        push_one(16'h0C0C);
        repeat (12) step();
        chk("pre-reset busy", busy, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        exp_cmd.delete();
        exp_out.delete();
        plans.delete();
        model_acks = 0;
        chk("mid reset cmd", cmd, 16'h0);
        chk("mid reset busy", busy, 1'b0);
        chk("mid reset empty", empty, 1'b1);
        chk("mid reset err", err, 1'b0);
        chk("mid reset ack_cnt", ack_cnt, 8'd0);
        chk("mid reset send_cmd", send_cmd, 1'b0);
        step();
        rst_n = 1'b1;
        repeat (20) step();
        chk("post reset idle", busy, 1'b0);
        chk("post reset empty", empty, 1'b1);
        expect_cmd(16'h5A5A, mk(1, 1, ACK));
        push_one(16'h5A5A);
        wait_quiet("post reset quiet", 100);
        chk("post reset ack_cnt", ack_cnt, 8'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
